alu_serial_ctrl: RTL

Bit-serial sequencer that drives a single 1-bit ALU slice across WIDTH bit positions, LSB first, to run one WIDTH-bit operation per transaction.
- Accepts operands and a 3-bit select through a valid/ready input handshake.
- Carries the slice carry between cycles in a register, shifts result bits into a result register, and presents the result plus flags through a valid/ready output handshake.
- Sits between the register file / front end and the 1-bit datapath, replacing a WIDTH-wide ripple ALU.

---
 rtl/alu_serial_pkg.sv | 28 ++
 rtl/alu_bit_slice.sv | 45 ++++
 rtl/alu_serial_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg
//   Shared definitions for the bit-serial ALU controller and its 1-bit slice:
//   operation select codes, FSM state encoding and a small op-class helper.
//   Optional feature macro used elsewhere: ALU_SERIAL_OVERFLOW_EN.
package alu_serial_pkg;

  // 3-bit operation select codes
  localparam logic [2:0] OP_AND      = 3'b000;
  localparam logic [2:0] OP_NOT      = 3'b001;
  localparam logic [2:0] OP_OR       = 3'b010;
  localparam logic [2:0] OP_XOR      = 3'b011;
  localparam logic [2:0] OP_ADD      = 3'b100;
  localparam logic [2:0] OP_SUB      = 3'b101;
  localparam logic [2:0] OP_TRANSFER = 3'b110;
  localparam logic [2:0] OP_TEST     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ADD and SUB are the only ops that carry between bit positions
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice
//   Purely combinational 1-bit ALU slice evaluated once per bit position by
//   the serial controller.
//   Ports:
//     a, b       operand bits at the current position
//     carry_in   carry from the previous (lower) position
//     select     3-bit operation code
//     out        slice result bit
//     carry_out  carry to the next position (ADD/SUB only, else 0)
//     and_bit    raw a&b, used for TEST zero detection
module alu_bit_slice
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic [2:0] select,
  output logic       out,
  output logic       carry_out,
  output logic       and_bit
);

  logic b_eff;

  // SUB is a + ~b + 1; the +1 comes from the controller's initial carry
  assign b_eff   = (select == OP_SUB) ? ~b : b;
  assign and_bit = a & b;

  always_comb begin
    out       = a;
    carry_out = 1'b0;
    case (select)
      OP_AND:  out = a & b;
      OP_NOT:  out = ~a;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_ADD, OP_SUB: begin
        out       = a ^ b_eff ^ carry_in;
        carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
      end
      default: out = a;  // TRANSFER, TEST
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
//   Bit-serial sequencer: runs one WIDTH-bit operation through a single
//   1-bit slice, LSB first, one bit per clock.
//   Optional feature macro: ALU_SERIAL_OVERFLOW_EN (signed overflow flag for
//   ADD/SUB; when undefined overflow_flag is tied to 0).
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     in_valid/in_ready   operand handshake (ready only in IDLE)
//     a, b, select        operands and op code
//     out_valid/out_ready result handshake (valid only in DONE)
//     result              WIDTH-bit result, 0 outside DONE
//     carry_flag          final carry, ADD/SUB only
//     zero_flag           zero detect ((a&b)==0 for TEST)
//     overflow_flag       signed overflow, ADD/SUB only
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             overflow_flag
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   count;
  logic               carry_q;
  logic               zero_q;

  logic               s_out, s_cout, s_and;
  logic               zbit;
  logic [WIDTH:0]     res_cat;
  logic               done;

  alu_bit_slice u_slice (
    .a         (a_q[count]),
    .b         (b_q[count]),
    .carry_in  (carry_q),
    .select    (op_q),
    .out       (s_out),
    .carry_out (s_cout),
    .and_bit   (s_and)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_cat = {s_out, res_q};
  assign zbit    = (op_q == OP_TEST) ? s_and : s_out;
  assign done    = (state_q == ST_DONE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (count == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      count   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= select;
            res_q   <= '0;
            count   <= '0;
            carry_q <= (select == OP_SUB);  // the +1 of two's complement
            zero_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          res_q  <= res_cat[WIDTH:1];
          zero_q <= zero_q & ~zbit;
          count  <= count + CNT_W'(1);
          if (is_arith(op_q)) carry_q <= s_cout;
        end
        default: ;  // DONE holds everything stable
      endcase
    end
  end

`ifdef ALU_SERIAL_OVERFLOW_EN
  // Carry into the MSB is the carry register value while the MSB is evaluated.
  logic cin_msb;

  always_ff @(posedge clk) begin
    if (reset) begin
      cin_msb <= 1'b0;
    end else if (state_q == ST_IDLE && in_valid) begin
      cin_msb <= 1'b0;
    end else if (state_q == ST_RUN && count == LAST) begin
      cin_msb <= carry_q;
    end
  end

  assign overflow_flag = done & is_arith(op_q) & (cin_msb ^ carry_q);
`else
  assign overflow_flag = 1'b0;
`endif

  // Outputs read 0 everywhere except DONE
  assign result     = done ? res_q : '0;
  assign carry_flag = done & is_arith(op_q) & carry_q;
  assign zero_flag  = done & zero_q;

endmodule
